dcpu_int_queue: RTL and testbench

Parametrised interrupt queue and arbiter for the dcpu16 core. It collects interrupt messages from N hardware devices and from the CPU's software `INT`, and buffers them in a FIFO of configurable depth. It delivers them one at a time to the CPU at instruction boundaries, honouring the `IAQ` (queue-only) mode. On overflow it enters the sticky "fire" state defined by the dcpu16 specification.

---
 rtl/dcpu_pkg.sv | 16 +
 rtl/int_rr_arbiter.sv | 50 +++++
 rtl/dcpu_int_queue.sv | 120 ++++++++++++
 tb/tb_dcpu_int_queue.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/dcpu_pkg.sv
// Shared types and default sizes for the dcpu16 interrupt queue.
package dcpu_pkg;

    localparam int DEPTH_DEF = 256;
    localparam int N_SRC_DEF = 4;
    localparam int MSG_W_DEF = 16;

    typedef logic [MSG_W_DEF-1:0] msg_t;

    // Q_FIRE is the sticky overflow state; only reset leaves it.
    typedef enum logic {
        Q_RUN  = 1'b0,
        Q_FIRE = 1'b1
    } int_state_t;

endpackage

// File: rtl/int_rr_arbiter.sv
// N-way round-robin arbiter. The search starts at the pointer, and the
// pointer moves one past the winner only when the caller asserts advance.
module int_rr_arbiter #(
    parameter  int N     = 4,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req,
    input  logic             advance,
    output logic [N-1:0]     grant_onehot,
    output logic [IDX_W-1:0] grant_idx
);

    logic [IDX_W-1:0] ptr_q;

    // First requester at or after the pointer, wrapping modulo N.
    always_comb begin
        int               j;
        logic             found;
        logic [IDX_W-1:0] idx;
        // NOTE: every variable written here gets a default first so no latch is inferred.
        j            = 0;
        found        = 1'b0;
        idx          = '0;
        grant_onehot = '0;
        grant_idx    = '0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_q) + i;
            if (j >= N) j = j - N;
            idx = IDX_W'(j);
            if (!found && req[idx]) begin
                found             = 1'b1;
                grant_onehot[idx] = 1'b1;
                grant_idx         = idx;
            end
        end
    end

    // Pointer register; it moves only on a granted hardware request.
    always_ff @(negedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else if (advance) begin
            // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
            ptr_q <= (grant_idx == IDX_W'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/dcpu_int_queue.sv
// Interrupt queue for the dcpu16 core: software INT has absolute priority,
// hardware sources share round-robin, and messages are buffered in a FIFO
// until the CPU takes them. An overflow locks the queue in Q_FIRE.
module dcpu_int_queue
    import dcpu_pkg::*;
#(
    parameter  int DEPTH = DEPTH_DEF,
    parameter  int N_SRC = N_SRC_DEF,
    parameter  int MSG_W = MSG_W_DEF,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               CORE_CLK,
    input  logic               RESET_N,
    input  logic [N_SRC-1:0]       SRC_req,
    input  logic [N_SRC*MSG_W-1:0] SRC_msg,
    output logic [N_SRC-1:0]       SRC_ack,
    input  logic               SW_req,
    input  logic [MSG_W-1:0]   SW_msg,
    output logic               SW_ack,
    input  logic               IAQ_en,
    input  logic               IA_zero,
    output logic               INT_valid,
    output logic [MSG_W-1:0]   INT_msg,
    input  logic               INT_ready,
    output logic [CNT_W-1:0]   COUNT,
    output logic               FIRE
);

    localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    int_state_t       state_q, state_d;
    logic [MSG_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic [N_SRC-1:0] src_ack_q;
    logic             sw_ack_q;

    logic [N_SRC-1:0] hw_onehot;
    logic [IDX_W-1:0] hw_idx;
    logic             hw_grant, any_grant;
    logic [MSG_W-1:0] grant_msg;
    logic             full, empty, int_valid, pop, push, overflow;

    assign hw_grant  = !SW_req && (|SRC_req);
    assign any_grant = SW_req || (|SRC_req);
    assign full      = (count_q == CNT_W'(DEPTH));
    assign empty     = (count_q == '0);
    assign grant_msg = SW_req ? SW_msg : SRC_msg[int'(hw_idx)*MSG_W +: MSG_W];

    int_rr_arbiter #(.N(N_SRC)) u_arb (
        .clk          (CORE_CLK),
        .rst_n        (RESET_N),
        .req          (SRC_req),
        .advance      (hw_grant),
        .grant_onehot (hw_onehot),
        .grant_idx    (hw_idx)
    );

    // FSM state register.
    always_ff @(negedge CORE_CLK or negedge RESET_N) begin
        if (!RESET_N) state_q <= Q_RUN;
        else          state_q <= state_d;
    end

    // Next state plus push/pop decisions; Q_FIRE freezes the FIFO.
    always_comb begin
        state_d   = state_q;
        int_valid = 1'b0;
        pop       = 1'b0;
        push      = 1'b0;
        overflow  = 1'b0;
        case (state_q)
            Q_RUN: begin
                int_valid = !empty && !IAQ_en;
                pop       = int_valid && INT_ready;
                push      = any_grant && !IA_zero && (!full || pop);
                overflow  = any_grant && !IA_zero && full && !pop;
                if (overflow) state_d = Q_FIRE;
            end
            Q_FIRE: state_d = Q_FIRE;
            default: state_d = Q_RUN;
        endcase
    end

    // Pointers, occupancy and registered grant pulses.
    always_ff @(negedge CORE_CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            src_ack_q <= '0;
            sw_ack_q  <= 1'b0;
        end else begin
            sw_ack_q  <= SW_req;
            src_ack_q <= SW_req ? '0 : hw_onehot;
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage write port.
    // NOTE: the storage array has no reset; the pointers and count define which entries are live.
    always_ff @(negedge CORE_CLK) begin
        if (push) mem[wr_ptr_q] <= grant_msg;
    end

    assign INT_valid = int_valid;
    assign INT_msg   = int_valid ? mem[rd_ptr_q] : '0;
    assign COUNT     = count_q;
    assign FIRE      = (state_q == Q_FIRE);
    assign SRC_ack   = src_ack_q;
    assign SW_ack    = sw_ack_q;

endmodule

// File: tb/tb_dcpu_int_queue.sv
// Directed bench for dcpu_int_queue (DEPTH=4, N_SRC=4). The DUT moves on the
// falling edge; the bench samples and drives just after the rising edge.
module tb_dcpu_int_queue;

    localparam int DEPTH = 4;
    localparam int N_SRC = 4;
    localparam int MSG_W = 16;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                   core_clk;
    logic                   reset_n;
    logic [N_SRC-1:0]       src_req;
    logic [N_SRC*MSG_W-1:0] src_msg;
    logic [N_SRC-1:0]       src_ack;
    logic                   sw_req;
    logic [MSG_W-1:0]       sw_msg;
    logic                   sw_ack;
    logic                   iaq_en;
    logic                   ia_zero;
    logic                   int_valid;
    logic [MSG_W-1:0]       int_msg;
    logic                   int_ready;
    logic [CNT_W-1:0]       count;
    logic                   fire;

    int n_checks = 0;
    int n_pass   = 0;

    dcpu_int_queue #(.DEPTH(DEPTH), .N_SRC(N_SRC), .MSG_W(MSG_W)) dut (
        .CORE_CLK  (core_clk),
        .RESET_N   (reset_n),
        .SRC_req   (src_req),
        .SRC_msg   (src_msg),
        .SRC_ack   (src_ack),
        .SW_req    (sw_req),
        .SW_msg    (sw_msg),
        .SW_ack    (sw_ack),
        .IAQ_en    (iaq_en),
        .IA_zero   (ia_zero),
        .INT_valid (int_valid),
        .INT_msg   (int_msg),
        .INT_ready (int_ready),
        .COUNT     (count),
        .FIRE      (fire)
    );

    initial core_clk = 1'b1;
    always #5 core_clk = ~core_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One DUT edge, then land on the following rising edge to sample.
    task automatic tick();
        @(negedge core_clk);
        @(posedge core_clk);
    endtask

    task automatic pulse_reset();
        reset_n = 1'b0;
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        src_req   = 4'hF;
        src_msg   = {16'h0333, 16'h0022, 16'h0101, 16'h0011};
        sw_req    = 1'b0;
        sw_msg    = '0;
        iaq_en    = 1'b0;
        ia_zero   = 1'b0;
        int_ready = 1'b0;

        // Reset held with every source requesting.
        tick();
        tick();
        chk("rst_src_ack",   32'(src_ack),   32'h0);
        chk("rst_sw_ack",    32'(sw_ack),    32'h0);
        chk("rst_int_valid", 32'(int_valid), 32'h0);
        chk("rst_int_msg",   32'(int_msg),   32'h0);
        chk("rst_count",     32'(count),     32'h0);
        chk("rst_fire",      32'(fire),      32'h0);
        reset_n = 1'b1;
        tick();
        chk("rel_ack_src0",  32'(src_ack),   32'h1);
        chk("rel_valid",     32'(int_valid), 32'h1);
        chk("rel_msg",       32'(int_msg),   32'h0011);
        chk("rel_count",     32'(count),     32'h1);
        src_req = '0;
        tick();
        chk("rel_ack_drop",  32'(src_ack),   32'h0);
        int_ready = 1'b1;
        tick();
        chk("rel_pop_count", 32'(count),     32'h0);
        chk("rel_pop_valid", 32'(int_valid), 32'h0);
        int_ready = 1'b0;

        // Round-robin between src0 and src2, both held, CPU always ready.
        pulse_reset();
        src_req   = 4'b0101;
        int_ready = 1'b1;
        tick();
        chk("rr_ack1", 32'(src_ack), 32'h1);
        chk("rr_msg1", 32'(int_msg), 32'h0011);
        tick();
        chk("rr_ack2", 32'(src_ack), 32'h4);
        chk("rr_msg2", 32'(int_msg), 32'h0022);
        tick();
        chk("rr_ack3", 32'(src_ack), 32'h1);
        chk("rr_msg3", 32'(int_msg), 32'h0011);
        tick();
        chk("rr_ack4", 32'(src_ack), 32'h4);
        chk("rr_msg4", 32'(int_msg), 32'h0022);
        chk("rr_cnt4", 32'(count),   32'h1);
        src_req = '0;
        tick();
        chk("rr_drain", 32'(count), 32'h0);
        int_ready = 1'b0;

        // Software request beats src1 raised in the same cycle.
        sw_req  = 1'b1;
        sw_msg  = 16'hBEEF;
        src_req = 4'b0010;
        tick();
        chk("sw_first_sw",  32'(sw_ack),  32'h1);
        chk("sw_first_src", 32'(src_ack), 32'h0);
        sw_req = 1'b0;
        tick();
        chk("sw_next_sw",  32'(sw_ack),  32'h0);
        chk("sw_next_src", 32'(src_ack), 32'h2);
        chk("sw_count",    32'(count),   32'h2);
        src_req   = '0;
        int_ready = 1'b1;
        #1;
        chk("sw_deliver1", 32'(int_msg), 32'hBEEF);
        tick();
        chk("sw_deliver2", 32'(int_msg), 32'h0101);
        tick();
        chk("sw_drain", 32'(count), 32'h0);
        int_ready = 1'b0;

        // Queue-only mode: three pushes held back, then released.
        iaq_en = 1'b1;
        sw_req = 1'b1;
        sw_msg = 16'hA001;
        tick();
        sw_msg = 16'hA002;
        tick();
        sw_msg = 16'hA003;
        tick();
        sw_req = 1'b0;
        chk("iaq_count", 32'(count),     32'h3);
        chk("iaq_valid", 32'(int_valid), 32'h0);
        iaq_en    = 1'b0;
        int_ready = 1'b1;
        #1;
        chk("iaq_rise_valid", 32'(int_valid), 32'h1);
        chk("iaq_pop1",       32'(int_msg),   32'hA001);
        tick();
        chk("iaq_pop2", 32'(int_msg), 32'hA002);
        chk("iaq_cnt2", 32'(count),   32'h2);
        tick();
        chk("iaq_pop3", 32'(int_msg), 32'hA003);
        tick();
        chk("iaq_cnt0",  32'(count),     32'h0);
        chk("iaq_empty", 32'(int_valid), 32'h0);
        int_ready = 1'b0;

        // Overflow on a DEPTH=4 queue.
        pulse_reset();
        sw_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            sw_msg = 16'hB000 + 16'(i);
            tick();
        end
        chk("ovf_full_count", 32'(count), 32'h4);
        chk("ovf_full_fire",  32'(fire),  32'h0);
        sw_msg    = 16'hB005;
        int_ready = 1'b1;
        tick();
        chk("ovf_pp_count", 32'(count),   32'h4);
        chk("ovf_pp_fire",  32'(fire),    32'h0);
        chk("ovf_pp_head",  32'(int_msg), 32'hB002);
        int_ready = 1'b0;
        sw_msg    = 16'hB006;
        tick();
        chk("ovf_ack",   32'(sw_ack),    32'h1);
        chk("ovf_fire",  32'(fire),      32'h1);
        chk("ovf_valid", 32'(int_valid), 32'h0);
        chk("ovf_count", 32'(count),     32'h4);
        sw_req    = 1'b0;
        int_ready = 1'b1;
        src_req   = 4'b0001;
        tick();
        chk("fire_src_ack", 32'(src_ack),   32'h1);
        chk("fire_count",   32'(count),     32'h4);
        chk("fire_valid",   32'(int_valid), 32'h0);
        src_req = '0;
        tick();
        tick();
        chk("fire_sticky", 32'(fire),  32'h1);
        chk("fire_hold",   32'(count), 32'h4);
        int_ready = 1'b0;
        pulse_reset();
        chk("fire_clear",       32'(fire),  32'h0);
        chk("fire_clear_count", 32'(count), 32'h0);

        // IA == 0: the request is acked and dropped.
        ia_zero = 1'b1;
        src_req = 4'b1000;
        tick();
        chk("iaz_ack",   32'(src_ack),   32'h8);
        chk("iaz_count", 32'(count),     32'h0);
        chk("iaz_valid", 32'(int_valid), 32'h0);
        reset_n = 1'b0;
        #1;
        chk("iaz_reset_ack", 32'(src_ack), 32'h0);
        reset_n = 1'b1;
        src_req = '0;
        ia_zero = 1'b0;
        tick();
        chk("iaz_after", 32'(count), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
